// File: rtl/param_datapath.sv
// Accumulator-machine datapath: PC/IR/MAR/MDR/ACC, Z/N/C flags, 8-op ALU,
// plus a wait-state memory handshake that sequences reads and writes.
module param_datapath #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int OP_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              muxPC,
    input  logic              muxMAR,
    input  logic              muxACC,
    input  logic              loadPC,
    input  logic              loadIR,
    input  logic              loadMAR,
    input  logic              loadACC,
    input  logic              loadMDR,
    input  logic              storeMEM,
    input  logic [2:0]        opALU,
    input  logic [DATA_W-1:0] MemQ,
    input  logic              MemAck,
    output logic              zflag,
    output logic              nflag,
    output logic              cflag,
    output logic [OP_W-1:0]   opcode,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemD,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } mem_state_t;

    mem_state_t        state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] mar_r;
    logic [DATA_W-1:0] ir_r;
    logic [DATA_W-1:0] mdr_r;
    logic [DATA_W-1:0] acc_r;
    logic              z_r;
    logic              n_r;
    logic              c_r;
    logic              mem_rd_r;
    logic              mem_wr_r;
    logic              busy_r;

    logic [ADDR_W-1:0] addr_field_s;
    logic [ADDR_W-1:0] pc_next_s;
    logic [ADDR_W-1:0] mar_next_s;
    logic [DATA_W-1:0] alu_s;
    logic              carry_s;
    logic [DATA_W-1:0] acc_next_s;
    logic              c_next_s;

    assign addr_field_s = ir_r[ADDR_W-1:0];

    // ALU: carry_s defaults to the held flag so logic ops leave C untouched
    always_comb begin
        alu_s   = '0;
        carry_s = c_r;
        case (opALU)
            3'b000:  alu_s = mdr_r;
            3'b001:  {carry_s, alu_s} = {1'b0, acc_r} + {1'b0, mdr_r};
            3'b010:  {carry_s, alu_s} = {1'b0, acc_r} - {1'b0, mdr_r};
            3'b011:  alu_s = acc_r & mdr_r;
            3'b100:  alu_s = acc_r | mdr_r;
            3'b101:  alu_s = acc_r ^ mdr_r;
            3'b110: begin
                alu_s   = {acc_r[DATA_W-2:0], 1'b0};
                carry_s = acc_r[DATA_W-1];
            end
            3'b111:  alu_s = ~acc_r;
            default: alu_s = '0;
        endcase
    end

    // Source selection for PC, MAR and ACC
    always_comb begin
        if (muxPC) begin
            pc_next_s = addr_field_s;
        end else begin
            pc_next_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
        if (muxMAR) begin
            mar_next_s = addr_field_s;
        end else begin
            mar_next_s = pc_r;
        end
        if (muxACC) begin
            acc_next_s = mdr_r;
            c_next_s   = c_r;
        end else begin
            acc_next_s = alu_s;
            c_next_s   = carry_s;
        end
    end

    // Architectural registers and flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r  <= '0;
            ir_r  <= '0;
            mar_r <= '0;
            acc_r <= '0;
            z_r   <= 1'b0;
            n_r   <= 1'b0;
            c_r   <= 1'b0;
        end else begin
            if (loadPC) begin
                pc_r <= pc_next_s;
            end
            if (loadIR) begin
                ir_r <= mdr_r;
            end
            if (loadMAR) begin
                mar_r <= mar_next_s;
            end
            if (loadACC) begin
                acc_r <= acc_next_s;
                z_r   <= (acc_next_s == '0);
                n_r   <= acc_next_s[DATA_W-1];
                c_r   <= c_next_s;
            end
        end
    end

    // Memory handshake: one transaction at a time, read wins a tie with store
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            mdr_r    <= '0;
            mem_rd_r <= 1'b0;
            mem_wr_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (loadMDR) begin
                        state_r  <= ST_READ;
                        mem_rd_r <= 1'b1;
                        busy_r   <= 1'b1;
                    end else if (storeMEM) begin
                        state_r  <= ST_WRITE;
                        mem_wr_r <= 1'b1;
                        busy_r   <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (MemAck) begin
                        mdr_r    <= MemQ;
                        state_r  <= ST_IDLE;
                        mem_rd_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (MemAck) begin
                        state_r  <= ST_IDLE;
                        mem_wr_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    mem_rd_r <= 1'b0;
                    mem_wr_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign zflag   = z_r;
    assign nflag   = n_r;
    assign cflag   = c_r;
    assign opcode  = ir_r[DATA_W-1 -: OP_W];
    assign MemAddr = mar_r;
    assign MemD    = acc_r;
    assign mem_rd  = mem_rd_r;
    assign mem_wr  = mem_wr_r;
    assign busy    = busy_r;

endmodule
